// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: FSM states, opcodes and IR field positions.
// Build option MULDIV_EN adds the MUL/DIV instruction class; without it those opcodes decode as illegal.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALTED
    } state_t;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Instruction classes share one execute sequence each.
    typedef enum logic [2:0] {
        CLS_ALU3,
        CLS_ALU2,
        CLS_LD,
        CLS_MULDIV,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_ALU3;
            OP_NEG, OP_NOT:                 cls = CLS_ALU2;
            OP_LD:                          cls = CLS_LD;
`ifdef MULDIV_EN
            OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
`endif
            OP_HALT:                        cls = CLS_HALT;
            default:                        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_decode_4_16.sv
// 4-bit register field to 16-bit one-hot enable; all zeros when disabled.
module reg_decode_4_16 (
    input  logic [3:0]  i_sel,
    input  logic        i_en,
    output logic [15:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM: fetch, decode and execute sequencing of datapath strobes.
// Build option MULDIV_EN enables MUL/DIV sequencing; otherwise MUL, DIV, HIin, LOin, Zhiout stay 0.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    input  logic [31:0] IR,
    input  logic        MemDone,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhiout,
    output logic        HIin,
    output logic        LOin,
    output logic        AND,
    output logic        OR,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        SHR,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        Halted,
    output logic        Illegal,
    output logic [15:0] InstrCount
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr_count;
    logic        r_illegal;

    logic [4:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    op_class_t   w_cls;
    logic        w_unused_ir;

    logic        w_end_instr;
    logic        w_set_illegal;
    logic        w_opsel;
    logic        w_rout_en;
    logic [3:0]  w_rout_sel;
    logic        w_rin_en;

    assign w_op        = IR[OP_HI:OP_LO];
    assign w_ra        = IR[RA_HI:RA_LO];
    assign w_rb        = IR[RB_HI:RB_LO];
    assign w_rc        = IR[RC_HI:RC_LO];
    assign w_cls       = op_class(w_op);
    assign w_unused_ir = ^IR[RC_LO-1:0];

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            r_state       <= ST_IDLE;
            r_instr_count <= '0;
            r_illegal     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_end_instr) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_end_instr   = 1'b0;
        w_set_illegal = 1'b0;
        w_opsel       = 1'b0;
        w_rout_en     = 1'b0;
        w_rout_sel    = w_rb;
        w_rin_en      = 1'b0;
        PCout         = 1'b0;
        MARin         = 1'b0;
        IncPC         = 1'b0;
        Read          = 1'b0;
        MDRin         = 1'b0;
        MDRout        = 1'b0;
        IRin          = 1'b0;
        Yin           = 1'b0;
        Zin           = 1'b0;
        Zlowout       = 1'b0;
        Zhiout        = 1'b0;
        HIin          = 1'b0;
        LOin          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (Run) begin
                    w_next = ST_F0;
                end
            end
            ST_F0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                w_next = ST_F1;
            end
            ST_F1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (MemDone) begin
                    w_next = ST_F2;
                end
            end
            ST_F2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                w_next = ST_T3;
            end
            ST_T3: begin
                case (w_cls)
                    CLS_ALU3, CLS_MULDIV: begin
                        w_rout_en = 1'b1;
                        Yin       = 1'b1;
                        w_next    = ST_T4;
                    end
                    CLS_ALU2: begin
                        w_rout_en = 1'b1;
                        w_opsel   = 1'b1;
                        Zin       = 1'b1;
                        w_next    = ST_T4;
                    end
                    CLS_LD: begin
                        w_rout_en = 1'b1;
                        MARin     = 1'b1;
                        w_next    = ST_T4;
                    end
                    CLS_HALT: begin
                        w_next = ST_HALTED;
                    end
                    default: begin
                        w_set_illegal = 1'b1;
                        w_next        = ST_HALTED;
                    end
                endcase
            end
            ST_T4: begin
                case (w_cls)
                    CLS_ALU3, CLS_MULDIV: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rc;
                        w_opsel    = 1'b1;
                        Zin        = 1'b1;
                        w_next     = ST_T5;
                    end
                    CLS_ALU2: begin
                        Zlowout     = 1'b1;
                        w_rin_en    = 1'b1;
                        w_end_instr = 1'b1;
                    end
                    CLS_LD: begin
                        Read  = 1'b1;
                        MDRin = 1'b1;
                        if (MemDone) begin
                            w_next = ST_T5;
                        end
                    end
                    default: w_next = ST_IDLE;
                endcase
            end
            ST_T5: begin
                case (w_cls)
                    CLS_ALU3: begin
                        Zlowout     = 1'b1;
                        w_rin_en    = 1'b1;
                        w_end_instr = 1'b1;
                    end
                    CLS_LD: begin
                        MDRout      = 1'b1;
                        w_rin_en    = 1'b1;
                        w_end_instr = 1'b1;
                    end
                    CLS_MULDIV: begin
`ifdef MULDIV_EN
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
`endif
                        w_next  = ST_T6;
                    end
                    default: w_next = ST_IDLE;
                endcase
            end
            ST_T6: begin
`ifdef MULDIV_EN
                Zhiout = 1'b1;
                HIin   = 1'b1;
`endif
                w_end_instr = 1'b1;
            end
            ST_HALTED: begin
                w_next = ST_HALTED;
            end
            default: w_next = ST_IDLE;
        endcase

        // Instruction boundary: Run is only sampled here, so a mid-instruction drop lets it finish.
        if (w_end_instr) begin
            w_next = Run ? ST_F0 : ST_IDLE;
        end
    end

    assign AND = w_opsel && (w_op == OP_AND);
    assign OR  = w_opsel && (w_op == OP_OR);
    assign ADD = w_opsel && (w_op == OP_ADD);
    assign SUB = w_opsel && (w_op == OP_SUB);
    assign SHR = w_opsel && (w_op == OP_SHR);
    assign SHL = w_opsel && (w_op == OP_SHL);
    assign ROR = w_opsel && (w_op == OP_ROR);
    assign ROL = w_opsel && (w_op == OP_ROL);
    assign NEG = w_opsel && (w_op == OP_NEG);
    assign NOT = w_opsel && (w_op == OP_NOT);
`ifdef MULDIV_EN
    assign MUL = w_opsel && (w_op == OP_MUL);
    assign DIV = w_opsel && (w_op == OP_DIV);
`else
    assign MUL = 1'b0;
    assign DIV = 1'b0;
`endif

    reg_decode_4_16 u_rout_dec (
        .i_sel    (w_rout_sel),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

    reg_decode_4_16 u_rin_dec (
        .i_sel    (w_ra),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

    assign Halted     = (r_state == ST_HALTED);
    assign Illegal    = r_illegal;
    assign InstrCount = r_instr_count;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1, the single rising-edge clock.
REQ-002 SHALL have port Clear, input, 1, a synchronous active-low reset: Clear=0 at a rising Clock edge resets the block.
REQ-003 SHALL have port Run, input, 1; a level of 1 permits instruction execution.
REQ-004 SHALL have port IR, input, 32, the instruction register value from the datapath; fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
REQ-005 SHALL have port MemDone, input, 1, memory read-complete handshake.
REQ-006 SHALL have output ports PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhiout, HIin, LOin, each 1 bit, the datapath strobes.
REQ-007 SHALL have output ports AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, each 1 bit, ALU operation selects.
REQ-008 SHALL have output ports Rout and Rin, each 16 bits, one-hot general-register bus-drive and load enables for R0..R15.
REQ-009 SHALL have output ports Halted, 1 bit; Illegal, 1 bit; InstrCount, 16 bits.

Function
REQ-010 SHALL be a Moore FSM: all strobes decode from the current state and the IR fields only, and each strobe is 1 for exactly the cycles listed.
REQ-011 SHALL implement these states: IDLE, F0, F1, F2, T3, T4, T5, T6, HALTED.
REQ-012 IDLE SHALL assert no strobes; it goes to F0 when Run=1.
REQ-013 F0 SHALL assert PCout, MARin and IncPC, then go to F1.
REQ-014 F1 SHALL assert Read and MDRin every cycle while MemDone=0, and go to F2 in the cycle MemDone=1.
REQ-015 F2 SHALL assert MDRout and IRin, then go to T3; T3 decodes the new IR.
REQ-016 ADD/SUB/AND/OR/SHR/SHL/ROR/ROL SHALL sequence as: T3 Rout[Rb] and Yin; T4 Rout[Rc], the op select and Zin; T5 Zlowout and Rin[Ra]; then end of instruction.
REQ-017 NEG/NOT SHALL sequence as: T3 Rout[Rb], the op select and Zin; T4 Zlowout and Rin[Ra]; then end of instruction.
REQ-018 LD SHALL sequence as: T3 Rout[Rb] and MARin; T4 Read and MDRin, holding T4 until MemDone=1; T5 MDRout and Rin[Ra]; then end of instruction.
REQ-019 MUL/DIV SHALL sequence as: T3 Rout[Rb] and Yin; T4 Rout[Rc], the op select and Zin; T5 Zlowout and LOin; T6 Zhiout and HIin; then end of instruction.
REQ-020 At end of instruction the FSM SHALL increment InstrCount (0xFFFF wraps to 0x0000), then go to F0 if Run=1, else to IDLE.
REQ-021 Opcodes SHALL be: 00000 LD, 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00111 SHR, 01000 SHL, 01001 ROR, 01010 ROL, 01110 MUL, 01111 DIV, 10000 NEG, 10001 NOT, 11011 HALT.
REQ-022 HALT in T3 SHALL go to HALTED without incrementing InstrCount; any other opcode in T3 SHALL go to HALTED with Illegal=1.
REQ-023 HALTED SHALL hold Halted=1 and no strobes until reset, ignoring Run; Illegal holds its value until reset.
REQ-024 A Run deassertion mid-instruction SHALL NOT abort it: the instruction completes, then the FSM goes to IDLE.
REQ-025 At most one Rout bit and at most one Rin bit SHALL be 1 in any cycle.

Reset
REQ-026 Clear=0 SHALL force state IDLE, InstrCount=0, Halted=0 and Illegal=0 at the next edge, including mid-instruction and during a MemDone wait.
REQ-027 In the cycle after reset all strobe, Rout and Rin outputs SHALL be 0.

Configuration
REQ-028 With MULDIV_EN defined, MUL/DIV SHALL follow REQ-019; without it, opcodes 01110 and 01111 SHALL be illegal per REQ-022, and the MUL, DIV, HIin, LOin and Zhiout outputs SHALL be tied to 0.

Structure
REQ-029 The state encoding, opcode constants and IR field bit positions SHALL reside in a shared package, cpu_pkg.
REQ-030 A sub-module reg_decode_4_16 (4-bit field to 16-bit one-hot, with an enable) SHALL be instantiated for Rout and for Rin.

Verification
REQ-031 Scenario: IR=0x1A920000 (ADD R5,R2,R4), MemDone=1 in F1 -> T3 Rout=0x0004 and Yin; T4 Rout=0x0010, ADD and Zin; T5 Rin=0x0020; InstrCount 0 to 1; F0 follows.
REQ-032 Scenario: MemDone held 0 for 3 cycles in F1 -> Read and MDRin high for 4 cycles; F2 starts the cycle after MemDone=1.
REQ-033 Scenario: IR=0x70120000 (MUL) with MULDIV_EN -> LOin in T5 and HIin in T6; without MULDIV_EN -> HALTED, Illegal=1, InstrCount unchanged.
REQ-034 Scenario: IR=0xD8000000 (HALT) -> Halted=1 and Illegal=0, with no strobes for 10 cycles while Run=1.
REQ-035 Scenario: IR=0xF8000000 -> Illegal=1; then Clear=0 for one edge -> IDLE, Illegal=0, InstrCount=0.
REQ-036 Scenario: Clear=0 during T4 of ADD -> the next cycle is IDLE with Rin=0; Run=1 then restarts at F0.
